alu_stage: RTL and testbench
============================

ALU_STAGE -- requirements
Module: alu_stage

Interface
- REQ-001: clk  input  1  rising-edge clock for all state.
- REQ-002: rst_n  input  1  asynchronous, active-low reset.
- REQ-003: in_valid  input  1  operation request this cycle.
- REQ-004: in_ready  output  1  stage can accept; equals (state==IDLE).
- REQ-005: op  input  4  opcode, encoding in Function.
- REQ-006: a, b  input  8 each  operands from register bank read ports a/b.
- REQ-007: ri_dst  input  3  destination register index.
- REQ-008: wb_en  input  1  request register write of result.
- REQ-009: d  output  8  write data to register bank d.
- REQ-010: ri_d  output  3  write index to register bank ri_d.
- REQ-011: rw  output  1  register bank write enable; one-cycle pulse per write.
- REQ-012: flags  output  4  {Z,N,C,V} at bits [3:0].
- REQ-013: busy  output  1  high while a multi-cycle multiply is in progress.

Function
- REQ-014: Accept on rising edge where in_valid && in_ready; otherwise inputs are ignored, including while busy.
- REQ-015: Opcodes: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 NOT ~a, 6 SHL a<<1, 7 SHR a>>1 (logical), 8 MOV b, 9 CMP (a-b, flags only), 10 MUL (a*b low byte), 11-15 NOP.
- REQ-016: Single-cycle ops register d, ri_d, flags on the accept edge; rw is high for exactly the following cycle iff wb_en=1 and op writes (0-8, 10).
- REQ-017: CMP, NOP and wb_en=0 leave rw=0 and d/ri_d unchanged; NOP also leaves flags unchanged.
- REQ-018: d and ri_d hold their last written value when rw=0.
- REQ-019: Z = result==0; N = result[7].
- REQ-020: C = carry-out for ADD; borrow (a<b unsigned) for SUB/CMP; shifted-out bit for SHL/SHR; high-byte-nonzero for MUL; 0 otherwise.
- REQ-021: V = signed overflow for ADD/SUB/CMP; 0 otherwise.
- REQ-022: Back-to-back single-cycle ops are accepted every cycle; rw stays high across consecutive writing ops.
- REQ-023: FSM states IDLE, MUL; IDLE->MUL on accepted MUL; MUL runs exactly 8 shift-add iteration edges, then MUL->IDLE, registering d/flags; rw high the cycle after (latency 9 cycles from accept).
- REQ-024: in_ready=0 and busy=1 for the whole MUL state.

Reset
- REQ-025: While rst_n=0: d=0, ri_d=0, rw=0, flags=0, busy=0, state=IDLE, in_ready=1.
- REQ-026: Reset during MUL aborts it; no rw pulse for the aborted op occurs after release.

Configuration
- REQ-027: Macro ALU_STAGE_MUL_EN defined: MUL (op 10) implemented per REQ-023/024.
- REQ-028: ALU_STAGE_MUL_EN undefined: op 10 behaves as NOP, busy tied 0, FSM reduced to IDLE only, no multiplier logic.

Structure
- REQ-029: Package alu_pkg holds the opcode enum, flag bit index constants, DATA_W=8, REG_IDX_W=3; shared with the register bank bench.
- REQ-030: Iterative multiplier is sub-module alu_mul_seq (start, 8-cycle done pulse, 16-bit product), instantiated only under ALU_STAGE_MUL_EN.

Verification
- REQ-031: ADD a=200 b=100 ri_dst=2 wb_en=1 -> next cycle rw=1, ri_d=2, d=44, flags Z0 N0 C1 V0.
- REQ-032: SUB a=5 b=5 -> d=0, Z=1, C=0; then CMP a=3 b=7 -> rw=0, d stays 0, N=1, C=1.
- REQ-033: ADD 1+1 to r1 then XOR 0xF0^0x0F to r3 on consecutive cycles -> rw high 2 cycles, d=2/ri_d=1 then d=0xFF/ri_d=3, N=1.
- REQ-034: MUL a=20 b=13 (macro on) -> in_ready low 8 cycles, rw on cycle 9, d=4, C=1; macro off -> rw=0, flags unchanged.
- REQ-035: MUL accepted, rst_n low at cycle 4 for 1 cycle -> all outputs 0, rw never pulses, in_ready=1 after release.
- REQ-036: ADD a=1 b=2 wb_en=0 -> rw=0, flags updated (all 0), d unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, flag bit positions and datapath widths.
// The register bank bench imports this package too.
package alu_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned FLAG_W    = 4;

    // Flag vector layout is {Z,N,C,V}
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Codes 11-15 are NOP
    typedef enum logic [OP_W-1:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpNot = 4'd5,
        OpShl = 4'd6,
        OpShr = 4'd7,
        OpMov = 4'd8,
        OpCmp = 4'd9,
        OpMul = 4'd10
    } opcode_e;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic [DATA_W-1:0] res,
                                                     input logic              c,
                                                     input logic              v);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_Z] = (res == '0);
        f[FLAG_N] = res[DATA_W-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, DATA_W iterations.
// done is high during the last iteration cycle and product carries the final value
// alongside it, so the consumer can register the result on that same edge.
// Only built when ALU_STAGE_MUL_EN is defined.
`ifdef ALU_STAGE_MUL_EN
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic                busy_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;

    // Accumulate the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Load operands on start, then shift one bit per cycle until the count wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign product = acc_d;

endmodule
`endif

// File: rtl/alu_stage.sv
// Single-issue ALU stage writing results to a register bank.
// Define ALU_STAGE_MUL_EN to add the multi-cycle multiply (op 10); without it op 10
// is a NOP, busy is tied low and the stage always accepts.
module alu_stage
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      op,
    input  logic [DATA_W-1:0]    a,
    input  logic [DATA_W-1:0]    b,
    input  logic [REG_IDX_W-1:0] ri_dst,
    input  logic                 wb_en,
    output logic [DATA_W-1:0]    d,
    output logic [REG_IDX_W-1:0] ri_d,
    output logic                 rw,
    output logic [FLAG_W-1:0]    flags,
    output logic                 busy
);

    localparam int unsigned MSB = DATA_W - 1;

    opcode_e op_e;
    logic    accept;

    logic [DATA_W:0]   sum_w;
    logic [DATA_W:0]   diff_w;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              alu_wr;
    logic              alu_fl;

    logic [DATA_W-1:0]    d_q, d_d;
    logic [REG_IDX_W-1:0] ri_d_q, ri_d_d;
    logic [FLAG_W-1:0]    flags_q, flags_d;
    logic                 rw_q, rw_d;

    assign op_e   = opcode_e'(op);
    assign accept = in_valid && in_ready;
    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};

`ifdef ALU_STAGE_MUL_EN
    typedef enum logic {StIdle, StMul} state_e;

    state_e                 state_q, state_d;
    logic                   mul_start;
    logic                   mul_done;
    logic [2*DATA_W-1:0]    mul_prod;
    logic                   mul_wb_q;
    logic [REG_IDX_W-1:0]   mul_ri_q;

    assign mul_start = accept && (op_e == OpMul);
    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StMul);

    alu_mul_seq u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // IDLE -> MUL on an accepted multiply, back once the multiplier reports done
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (mul_start) state_d = StMul;
            StMul:   if (mul_done)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register plus destination info held for the duration of the multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mul_wb_q <= 1'b0;
            mul_ri_q <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start) begin
                mul_wb_q <= wb_en;
                mul_ri_q <= ri_dst;
            end
        end
    end
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    // Single-cycle datapath; MUL and 11-15 fall to the default (no effect here)
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b0;
        alu_fl  = 1'b0;
        case (op_e)
            OpAdd: begin
                alu_res = sum_w[MSB:0];
                alu_c   = sum_w[DATA_W];
                alu_v   = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OpSub, OpCmp: begin
                alu_res = diff_w[MSB:0];
                alu_c   = diff_w[DATA_W];
                alu_v   = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
                alu_wr  = (op_e == OpSub);
                alu_fl  = 1'b1;
            end
            OpAnd: begin
                alu_res = a & b;
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OpOr: begin
                alu_res = a | b;
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OpXor: begin
                alu_res = a ^ b;
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OpNot: begin
                alu_res = ~a;
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OpShl: begin
                alu_res = a << 1;
                alu_c   = a[MSB];
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OpShr: begin
                alu_res = a >> 1;
                alu_c   = a[0];
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OpMov: begin
                alu_res = b;
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            default: ;
        endcase
    end

    // Result/flag update: d and ri_d only move on a write, rw is a one-cycle pulse
    always_comb begin
        d_d     = d_q;
        ri_d_d  = ri_d_q;
        flags_d = flags_q;
        rw_d    = 1'b0;
        if (accept && alu_fl) begin
            flags_d = pack_flags(alu_res, alu_c, alu_v);
        end
        if (accept && alu_wr && wb_en) begin
            d_d    = alu_res;
            ri_d_d = ri_dst;
            rw_d   = 1'b1;
        end
`ifdef ALU_STAGE_MUL_EN
        if (mul_done) begin
            flags_d = pack_flags(mul_prod[MSB:0], mul_prod[2*DATA_W-1:DATA_W] != '0, 1'b0);
            if (mul_wb_q) begin
                d_d    = mul_prod[MSB:0];
                ri_d_d = mul_ri_q;
                rw_d   = 1'b1;
            end
        end
`endif
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            ri_d_q  <= '0;
            flags_q <= '0;
            rw_q    <= 1'b0;
        end else begin
            d_q     <= d_d;
            ri_d_q  <= ri_d_d;
            flags_q <= flags_d;
            rw_q    <= rw_d;
        end
    end

    assign d     = d_q;
    assign ri_d  = ri_d_q;
    assign flags = flags_q;
    assign rw    = rw_q;

endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage. Stimulus pushes the expected output state for a
// given cycle; the monitor compares at each falling edge and flags any rw pulse
// that no queued expectation accounts for.
module tb_alu_stage;
    import alu_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [OP_W-1:0]      op;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [REG_IDX_W-1:0] ri_dst;
    logic                 wb_en;
    logic [DATA_W-1:0]    d;
    logic [REG_IDX_W-1:0] ri_d;
    logic                 rw;
    logic [FLAG_W-1:0]    flags;
    logic                 busy;

    typedef struct {
        int                   id;
        int                   due;
        logic                 rw;
        logic [DATA_W-1:0]    d;
        logic [REG_IDX_W-1:0] ri;
        logic [FLAG_W-1:0]    fl;
        logic                 rdy;
        logic                 bsy;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;
    int   next_id;

    alu_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .ri_dst   (ri_dst),
        .wb_en    (wb_en),
        .d        (d),
        .ri_d     (ri_d),
        .rw       (rw),
        .flags    (flags),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int t_due, input logic t_rw, input logic [7:0] t_d,
                            input logic [2:0] t_ri, input logic [3:0] t_fl,
                            input logic t_rdy, input logic t_bsy);
        exp_t e;
        e.id  = next_id;
        e.due = t_due;
        e.rw  = t_rw;
        e.d   = t_d;
        e.ri  = t_ri;
        e.fl  = t_fl;
        e.rdy = t_rdy;
        e.bsy = t_bsy;
        next_id++;
        exp_q.push_back(e);
    endtask

    // Drive one request on the next falling edge; it is accepted on the following rise
    task automatic op_vec(input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                          input logic [2:0] t_ri, input logic t_wb, input logic [7:0] e_d,
                          input logic [2:0] e_ri, input logic [3:0] e_fl, input logic e_rw);
        @(negedge clk);
        in_valid = 1'b1;
        op       = t_op;
        a        = t_a;
        b        = t_b;
        ri_dst   = t_ri;
        wb_en    = t_wb;
        push_exp(cyc + 1, e_rw, e_d, e_ri, e_fl, 1'b1, 1'b0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({rw, d, ri_d, flags, in_ready, busy} !== {e.rw, e.d, e.ri, e.fl, e.rdy, e.bsy}) begin
                errors++;
                $display("FAIL item%0d cycle %0d: got rw=%b d=%h ri_d=%0d flags=%b in_ready=%b busy=%b, want rw=%b d=%h ri_d=%0d flags=%b in_ready=%b busy=%b",
                         e.id, cyc, rw, d, ri_d, flags, in_ready, busy,
                         e.rw, e.d, e.ri, e.fl, e.rdy, e.bsy);
            end
        end else if (rw !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rw cycle %0d: got rw=%b d=%h ri_d=%0d, want rw=0",
                     cyc, rw, d, ri_d);
        end
    end

    initial begin
        int c;
        checks   = 0;
        errors   = 0;
        next_id  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        a        = '0;
        b        = '0;
        ri_dst   = '0;
        wb_en    = 1'b0;

        // Reset values while rst_n is held low
        push_exp(1, 1'b0, 8'h00, 3'd0, 4'b0000, 1'b1, 1'b0);
        push_exp(2, 1'b0, 8'h00, 3'd0, 4'b0000, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back single-cycle ops; flags are {Z,N,C,V}
        op_vec(4'd0,  8'd200, 8'd100, 3'd2, 1'b1, 8'h2C, 3'd2, 4'b0010, 1'b1); // ADD carry
        op_vec(4'd1,  8'd5,   8'd5,   3'd4, 1'b1, 8'h00, 3'd4, 4'b1000, 1'b1); // SUB zero
        op_vec(4'd9,  8'd3,   8'd7,   3'd5, 1'b1, 8'h00, 3'd4, 4'b0110, 1'b0); // CMP borrow
        op_vec(4'd0,  8'd1,   8'd1,   3'd1, 1'b1, 8'h02, 3'd1, 4'b0000, 1'b1); // ADD r1
        op_vec(4'd4,  8'hF0,  8'h0F,  3'd3, 1'b1, 8'hFF, 3'd3, 4'b0100, 1'b1); // XOR r3
        op_vec(4'd0,  8'd1,   8'd2,   3'd6, 1'b0, 8'hFF, 3'd3, 4'b0000, 1'b0); // ADD no wb
        op_vec(4'd1,  8'h80,  8'h01,  3'd7, 1'b1, 8'h7F, 3'd7, 4'b0001, 1'b1); // SUB overflow
        op_vec(4'd15, 8'h00,  8'h00,  3'd0, 1'b1, 8'h7F, 3'd7, 4'b0001, 1'b0); // NOP
        op_vec(4'd0,  8'h7F,  8'h01,  3'd0, 1'b1, 8'h80, 3'd0, 4'b0101, 1'b1); // ADD overflow
        op_vec(4'd6,  8'h81,  8'h00,  3'd1, 1'b1, 8'h02, 3'd1, 4'b0010, 1'b1); // SHL out bit
        op_vec(4'd7,  8'h01,  8'h00,  3'd2, 1'b1, 8'h00, 3'd2, 4'b1010, 1'b1); // SHR out bit
        op_vec(4'd2,  8'hCC,  8'hAA,  3'd3, 1'b1, 8'h88, 3'd3, 4'b0100, 1'b1); // AND
        op_vec(4'd3,  8'h0C,  8'h30,  3'd4, 1'b1, 8'h3C, 3'd4, 4'b0000, 1'b1); // OR
        op_vec(4'd5,  8'h0F,  8'h00,  3'd5, 1'b1, 8'hF0, 3'd5, 4'b0100, 1'b1); // NOT
        op_vec(4'd8,  8'h33,  8'h00,  3'd6, 1'b1, 8'h00, 3'd6, 4'b1000, 1'b1); // MOV zero
        @(negedge clk);
        in_valid = 1'b0;

        // Multiply 20*13 = 0x104
        @(negedge clk);
        c        = cyc;
        in_valid = 1'b1;
        op       = 4'd10;
        a        = 8'd20;
        b        = 8'd13;
        ri_dst   = 3'd5;
        wb_en    = 1'b1;
`ifdef ALU_STAGE_MUL_EN
        for (int k = 1; k <= 8; k++) begin
            push_exp(c + k, 1'b0, 8'h00, 3'd6, 4'b1000, 1'b0, 1'b1);
        end
        push_exp(c + 9, 1'b1, 8'h04, 3'd5, 4'b0010, 1'b1, 1'b0);
        // Requests offered while busy must be ignored
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            op     = 4'd0;
            a      = 8'd1;
            b      = 8'd1;
            ri_dst = 3'd7;
        end
`else
        push_exp(c + 1, 1'b0, 8'h00, 3'd6, 4'b1000, 1'b1, 1'b0);
`endif
        op_vec(4'd8, 8'h00, 8'h5A, 3'd6, 1'b1, 8'h5A, 3'd6, 4'b0000, 1'b1); // MOV
        @(negedge clk);
        in_valid = 1'b0;

        // Reset in the middle of a multiply
        @(negedge clk);
        c        = cyc;
        in_valid = 1'b1;
        op       = 4'd10;
        a        = 8'd20;
        b        = 8'd13;
        ri_dst   = 3'd1;
        wb_en    = 1'b1;
`ifdef ALU_STAGE_MUL_EN
        for (int k = 1; k <= 3; k++) begin
            push_exp(c + k, 1'b0, 8'h5A, 3'd6, 4'b0000, 1'b0, 1'b1);
        end
`else
        for (int k = 1; k <= 3; k++) begin
            push_exp(c + k, 1'b0, 8'h5A, 3'd6, 4'b0000, 1'b1, 1'b0);
        end
`endif
        for (int k = 4; k <= 16; k++) begin
            push_exp(c + k, 1'b0, 8'h00, 3'd0, 4'b0000, 1'b1, 1'b0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending items, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
